// File: rtl/ad_sched_pkg.sv
// Shared types and defaults for the three-channel ADC sample scheduler.
package ad_sched_pkg;

    localparam int unsigned CH_NUM    = 3;
    localparam int unsigned CH_W_DEF  = 24;
    localparam int unsigned DEPTH_DEF = 2;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        CH_AD1 = 2'd0,
        CH_AD2 = 2'd1,
        CH_AD3 = 2'd2
    } ch_tag_e;

    // Successor in the round-robin order; tag 3 is never produced.
    function automatic ch_tag_e next_ch(input ch_tag_e c);
        case (c)
            CH_AD1:  return CH_AD2;
            CH_AD2:  return CH_AD3;
            default: return CH_AD1;
        endcase
    endfunction

endpackage

// File: rtl/ad_sched_if.sv
// Sample-in / scheduled-out bundle between the ADC front ends, the scheduler and the DSP.
interface ad_sched_if
    import ad_sched_pkg::*;
#(
    parameter int unsigned CH_W  = CH_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic [CH_W-1:0]  ad1_data;
    logic [CH_W-1:0]  ad2_data;
    logic [CH_W-1:0]  ad3_data;
    logic             ad1_vld;
    logic             ad2_vld;
    logic             ad3_vld;
    logic [2:0]       ch_en;
    logic             clr_ovf;
    logic [CH_W-1:0]  sd_data;
    logic [1:0]       sd_ch;
    logic             sd_vld;
    logic             sd_rdy;
    logic [2:0]       ovf_flag;
    logic [CNT_W-1:0] ovf_cnt1;
    logic [CNT_W-1:0] ovf_cnt2;
    logic [CNT_W-1:0] ovf_cnt3;

    modport master (
        output ad1_data, ad2_data, ad3_data, ad1_vld, ad2_vld, ad3_vld,
        output ch_en, clr_ovf, sd_rdy,
        input  sd_data, sd_ch, sd_vld, ovf_flag, ovf_cnt1, ovf_cnt2, ovf_cnt3
    );

    modport slave (
        input  ad1_data, ad2_data, ad3_data, ad1_vld, ad2_vld, ad3_vld,
        input  ch_en, clr_ovf, sd_rdy,
        output sd_data, sd_ch, sd_vld, ovf_flag, ovf_cnt1, ovf_cnt2, ovf_cnt3
    );

endinterface

// File: rtl/ad_sched_fifo.sv
// Per-channel holding FIFO with flush, plus the channel's saturating drop counter and sticky flag.
module ad_sched_fifo
    import ad_sched_pkg::*;
#(
    parameter int unsigned CH_W  = CH_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic             i_clr,
    input  logic [CH_W-1:0]  i_data,
    output logic [CH_W-1:0]  o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CH_W-1:0]  r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_en;
    logic             w_wr_en;
    logic             w_drop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_rd_en = i_pop & ~w_empty & ~i_flush;
    assign w_wr_en = i_push & ~i_flush & (~w_full | w_rd_en);
    assign w_drop  = i_push & ~i_flush & w_full & ~w_rd_en;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
            if (w_rd_en) r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    // A clear coinciding with a drop leaves that drop as the first one counted.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= w_drop ? CNT_W'(1) : '0;
            r_ovf <= w_drop;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_ovf   = r_ovf;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/ad_sched.sv
// Round-robin merge of three ADC sample streams into one tagged valid/ready stream.
module ad_sched
    import ad_sched_pkg::*;
#(
    parameter int unsigned CH_W  = CH_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic       clk_sys,
    input  logic       rst,
    ad_sched_if.slave  bus
);
    logic [CH_NUM-1:0] w_vld;
    logic [CH_NUM-1:0] w_push;
    logic [CH_NUM-1:0] w_flush;
    logic [CH_NUM-1:0] w_pop;
    logic [CH_NUM-1:0] w_full;
    logic [CH_NUM-1:0] w_empty;
    logic [CH_NUM-1:0] w_req;
    logic [CH_NUM-1:0] w_ovf;
    logic [CH_W-1:0]   w_din   [CH_NUM];
    logic [CH_W-1:0]   w_fdata [CH_NUM];
    logic [CNT_W-1:0]  w_cnt   [CH_NUM];

    logic              w_load;
    logic              w_grant_vld;
    ch_tag_e           w_grant;
    ch_tag_e           w_c1;
    ch_tag_e           w_c2;

    logic              r_vld;
    logic [CH_W-1:0]   r_data;
    ch_tag_e           r_ch;
    ch_tag_e           r_rr;

    assign w_vld    = {bus.ad3_vld, bus.ad2_vld, bus.ad1_vld};
    assign w_din[0] = bus.ad1_data;
    assign w_din[1] = bus.ad2_data;
    assign w_din[2] = bus.ad3_data;
    assign w_push   = w_vld & bus.ch_en;
    assign w_flush  = ~bus.ch_en;
    assign w_req    = ~w_empty & bus.ch_en;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        ad_sched_fifo #(
            .CH_W  (CH_W),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk_sys (clk_sys),
            .rst     (rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_flush (w_flush[g]),
            .i_clr   (bus.clr_ovf),
            .i_data  (w_din[g]),
            .o_data  (w_fdata[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_ovf   (w_ovf[g]),
            .o_cnt   (w_cnt[g])
        );
    end

    assign w_load = ~r_vld | bus.sd_rdy;

    // Search rr, rr+1, rr+2 (mod 3) for the first enabled non-empty FIFO.
    always_comb begin
        w_c1        = next_ch(r_rr);
        w_c2        = next_ch(w_c1);
        w_grant     = r_rr;
        w_grant_vld = 1'b1;
        if (w_req[r_rr])      w_grant = r_rr;
        else if (w_req[w_c1]) w_grant = w_c1;
        else if (w_req[w_c2]) w_grant = w_c2;
        else                  w_grant_vld = 1'b0;
        w_pop = '0;
        if (w_load && w_grant_vld) w_pop[w_grant] = 1'b1;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_ch   <= CH_AD1;
            r_rr   <= CH_AD1;
        end else if (w_load) begin
            r_vld <= w_grant_vld;
            if (w_grant_vld) begin
                r_data <= w_fdata[w_grant];
                r_ch   <= w_grant;
                r_rr   <= next_ch(w_grant);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst) assert ((w_full & w_empty) == '0);
    end

    assign bus.sd_vld   = r_vld;
    assign bus.sd_data  = r_data;
    assign bus.sd_ch    = r_ch;
    assign bus.ovf_flag = w_ovf;
    assign bus.ovf_cnt1 = w_cnt[0];
    assign bus.ovf_cnt2 = w_cnt[1];
    assign bus.ovf_cnt3 = w_cnt[2];

endmodule

// File: tb/tb_ad_sched.sv
// Directed bench for ad_sched: queue-based reference model checked every cycle plus literal pins.
module tb_ad_sched;
    import ad_sched_pkg::*;

    localparam int unsigned CW = 24;
    localparam int unsigned DP = 2;
    localparam int unsigned NW = 8;
    localparam int          CNT_MAX = 255;

    logic clk_sys = 1'b0;
    logic rst     = 1'b0;

    ad_sched_if #(.CH_W(CW), .CNT_W(NW)) bus ();

    ad_sched #(.CH_W(CW), .DEPTH(DP), .CNT_W(NW)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel plus the output slot.
    logic [CW-1:0] mq [3][$];
    bit            m_vld;
    logic [CW-1:0] m_data;
    int            m_ch;
    int            m_rr;
    int            m_cnt [3];
    bit [2:0]      m_flag;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mq[c].delete();
            m_cnt[c] = 0;
        end
        m_vld  = 1'b0;
        m_data = '0;
        m_ch   = 0;
        m_rr   = 0;
        m_flag = '0;
    endtask

    task automatic model_step();
        bit [2:0]      en;
        bit [2:0]      v;
        logic [CW-1:0] d [3];
        bit            got;
        int            c;
        en   = bus.ch_en;
        v    = {bus.ad3_vld, bus.ad2_vld, bus.ad1_vld};
        d[0] = bus.ad1_data;
        d[1] = bus.ad2_data;
        d[2] = bus.ad3_data;
        if (!m_vld || bus.sd_rdy) begin
            got = 1'b0;
            for (int k = 0; k < 3; k++) begin
                c = (m_rr + k) % 3;
                if (!got && en[c] && mq[c].size() > 0) begin
                    m_data = mq[c].pop_front();
                    m_ch   = c;
                    m_rr   = (c + 1) % 3;
                    got    = 1'b1;
                end
            end
            m_vld = got;
        end
        if (bus.clr_ovf) begin
            m_flag = '0;
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            if (!en[k]) mq[k].delete();
            else if (v[k]) begin
                if (mq[k].size() < DP) mq[k].push_back(d[k]);
                else begin
                    m_flag[k] = 1'b1;
                    if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_sys or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    bit go = 1'b0;

    initial begin
        forever begin
            @(negedge clk_sys);
            if (go) begin
                chk("m_sd_vld", 32'(bus.sd_vld), 32'(m_vld));
                if (m_vld) begin
                    chk("m_sd_data", 32'(bus.sd_data), 32'(m_data));
                    chk("m_sd_ch", 32'(bus.sd_ch), 32'(m_ch));
                end
                chk("m_ovf_flag", 32'(bus.ovf_flag), 32'(m_flag));
                chk("m_ovf_cnt1", 32'(bus.ovf_cnt1), 32'(m_cnt[0]));
                chk("m_ovf_cnt2", 32'(bus.ovf_cnt2), 32'(m_cnt[1]));
                chk("m_ovf_cnt3", 32'(bus.ovf_cnt3), 32'(m_cnt[2]));
            end
        end
    end

    task automatic cyc();
        @(negedge clk_sys);
    endtask

    task automatic out_is(input string name, input logic [31:0] data, input logic [31:0] ch);
        chk({name, "_vld"}, 32'(bus.sd_vld), 32'd1);
        chk({name, "_data"}, 32'(bus.sd_data), data);
        chk({name, "_ch"}, 32'(bus.sd_ch), ch);
    endtask

    initial begin
        bus.ad1_data = '0; bus.ad2_data = '0; bus.ad3_data = '0;
        bus.ad1_vld  = 1'b0; bus.ad2_vld = 1'b0; bus.ad3_vld = 1'b0;
        bus.ch_en    = 3'b111;
        bus.clr_ovf  = 1'b0;
        bus.sd_rdy   = 1'b1;
        #1 rst = 1'b1;
        repeat (2) cyc();
        chk("rst_sd_vld", 32'(bus.sd_vld), 32'd0);
        chk("rst_sd_data", 32'(bus.sd_data), 32'd0);
        chk("rst_sd_ch", 32'(bus.sd_ch), 32'd0);
        chk("rst_ovf_flag", 32'(bus.ovf_flag), 32'd0);
        chk("rst_cnt_sum", 32'(bus.ovf_cnt1) + 32'(bus.ovf_cnt2) + 32'(bus.ovf_cnt3), 32'd0);
        rst = 1'b0;
        go  = 1'b1;
        cyc();

        // Single sample: visible exactly two cycles after the push.
        bus.ad1_data = 24'h123456; bus.ad1_vld = 1'b1;
        cyc(); bus.ad1_vld = 1'b0;
        chk("t1_not_yet", 32'(bus.sd_vld), 32'd0);
        cyc(); out_is("t1", 32'h123456, 32'd0);
        cyc(); chk("t1_gone", 32'(bus.sd_vld), 32'd0);

        // One ad3 sample moves rr back to ad1.
        bus.ad3_data = 24'h000333; bus.ad3_vld = 1'b1;
        cyc(); bus.ad3_vld = 1'b0;
        cyc(); out_is("rr_fix", 32'h000333, 32'd2);
        cyc();

        // Simultaneous strobes, twice.
        for (int b = 0; b < 2; b++) begin
            bus.ad1_data = 24'hA00000 + 24'(b); bus.ad1_vld = 1'b1;
            bus.ad2_data = 24'hB00000 + 24'(b); bus.ad2_vld = 1'b1;
            bus.ad3_data = 24'hC00000 + 24'(b); bus.ad3_vld = 1'b1;
            cyc();
            bus.ad1_vld = 1'b0; bus.ad2_vld = 1'b0; bus.ad3_vld = 1'b0;
            cyc(); out_is("t2_a", 32'hA00000 + 32'(b), 32'd0);
            cyc(); out_is("t2_b", 32'hB00000 + 32'(b), 32'd1);
            cyc(); out_is("t2_c", 32'hC00000 + 32'(b), 32'd2);
            cyc(); chk("t2_idle", 32'(bus.sd_vld), 32'd0);
        end

        // Backpressure on ad2: one held, two buffered, fourth dropped.
        bus.sd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ad2_data = 24'h200001 + 24'(i); bus.ad2_vld = 1'b1;
            if (i == 3) chk("t3_flag_before", 32'(bus.ovf_flag), 32'd0);
            cyc();
        end
        bus.ad2_vld = 1'b0;
        chk("t3_flag", 32'(bus.ovf_flag), 32'h2);
        chk("t3_cnt2", 32'(bus.ovf_cnt2), 32'd1);
        out_is("t3_hold0", 32'h200001, 32'd1);
        cyc(); out_is("t3_hold1", 32'h200001, 32'd1);
        bus.sd_rdy = 1'b1;
        cyc(); out_is("t3_s2", 32'h200002, 32'd1);
        cyc(); out_is("t3_s3", 32'h200003, 32'd1);
        cyc(); chk("t3_idle", 32'(bus.sd_vld), 32'd0);
        bus.clr_ovf = 1'b1;
        cyc(); bus.clr_ovf = 1'b0;
        chk("t3_cleared", 32'(bus.ovf_flag), 32'd0);

        // Saturation on ad3, clear, then clear coinciding with a drop.
        bus.sd_rdy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.ad3_data = 24'h300000 + 24'(i); bus.ad3_vld = 1'b1;
            cyc();
        end
        chk("t4_sat", 32'(bus.ovf_cnt3), 32'd255);
        chk("t4_flag", 32'(bus.ovf_flag), 32'h4);
        bus.ad3_vld = 1'b0; bus.clr_ovf = 1'b1;
        cyc(); bus.clr_ovf = 1'b0;
        chk("t4_clr_cnt", 32'(bus.ovf_cnt3), 32'd0);
        chk("t4_clr_flag", 32'(bus.ovf_flag), 32'd0);
        bus.ad3_vld = 1'b1; bus.clr_ovf = 1'b1;
        cyc(); bus.ad3_vld = 1'b0; bus.clr_ovf = 1'b0;
        chk("t4_clrdrop_cnt", 32'(bus.ovf_cnt3), 32'd1);
        chk("t4_clrdrop_flag", 32'(bus.ovf_flag), 32'h4);
        out_is("t4_held", 32'h300000, 32'd2);
        bus.sd_rdy = 1'b1;
        cyc(); out_is("t4_d1", 32'h300001, 32'd2);
        cyc(); out_is("t4_d2", 32'h300002, 32'd2);
        cyc(); chk("t4_idle", 32'(bus.sd_vld), 32'd0);
        bus.clr_ovf = 1'b1;
        cyc(); bus.clr_ovf = 1'b0;

        // Disable ad1 with one sample in the output slot and two buffered.
        bus.sd_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ad1_data = 24'h5A0001 + 24'(i); bus.ad1_vld = 1'b1;
            cyc();
        end
        bus.ch_en = 3'b110; bus.ad1_data = 24'h5AFFFF; bus.ad1_vld = 1'b1;
        cyc(); bus.ad1_vld = 1'b0;
        out_is("t5_pending", 32'h5A0001, 32'd0);
        bus.sd_rdy = 1'b1;
        cyc(); chk("t5_flushed", 32'(bus.sd_vld), 32'd0);
        bus.ch_en = 3'b111;
        cyc(); chk("t5_reenable", 32'(bus.sd_vld), 32'd0);
        cyc(); chk("t5_still_empty", 32'(bus.sd_vld), 32'd0);

        // Asynchronous reset with data in flight.
        bus.sd_rdy = 1'b0;
        bus.ad2_data = 24'h600001; bus.ad2_vld = 1'b1;
        bus.ad3_data = 24'h600003; bus.ad3_vld = 1'b1;
        cyc(); bus.ad2_data = 24'h600002; bus.ad3_vld = 1'b0;
        cyc(); bus.ad2_vld = 1'b0;
        cyc(); out_is("t6_before", 32'h600001, 32'd1);
        #2 rst = 1'b1;
        #1 chk("t6_async_vld", 32'(bus.sd_vld), 32'd0);
        chk("t6_async_data", 32'(bus.sd_data), 32'd0);
        cyc(); rst = 1'b0; bus.sd_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("t6_quiet", 32'(bus.sd_vld), 32'd0);
        end
        bus.ad3_data = 24'h700007; bus.ad3_vld = 1'b1;
        cyc(); bus.ad3_vld = 1'b0;
        cyc(); out_is("t6_new", 32'h700007, 32'd2);
        cyc(); chk("t6_end_idle", 32'(bus.sd_vld), 32'd0);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad_sched.md
# ad_sched

Round-robin scheduler that merges the three ADC sample streams (ad1/ad2/ad3, 24-bit, single-cycle `vld` strobes) into one tagged stream for the DSP datapath. It sits between the three `ad_top` instances and `dsp_top`. Each channel has a small holding FIFO. The block grants one sample at a time through a valid/ready output register and counts dropped samples per channel.

## Interface
Parameters:
- `CH_W`, 24: sample width
- `DEPTH`, 2: holding FIFO depth per channel (power of two, ≥2)
- `CNT_W`, 8: width of the per-channel drop counter

Ports:
- `clk_sys`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, asynchronous and active-high
- `ad1_data` / `ad2_data` / `ad3_data`  in  CH_W each  channel samples
- `ad1_vld` / `ad2_vld` / `ad3_vld`  in  1 each  one-cycle sample strobes
- `ch_en`  in  3  channel enable. Bit 0 = ad1, bit 1 = ad2, bit 2 = ad3.
- `clr_ovf`  in  1  one-cycle pulse that clears all drop counters and sticky flags
- `sd_data`  out  CH_W  scheduled sample
- `sd_ch`  out  2  channel tag: 0 = ad1, 1 = ad2, 2 = ad3. Value 3 is never driven.
- `sd_vld`  out  1  output valid
- `sd_rdy`  in  1  downstream ready
- `ovf_flag`  out  3  sticky per-channel drop flag
- `ovf_cnt1` / `ovf_cnt2` / `ovf_cnt3`  out  CNT_W each  saturating drop counters

## Operation
- Push: when `adN_vld` is high and `ch_en[N]` is high, the sample is written into FIFO N.
- Push while disabled: when `ch_en[N]` is low, `adN_vld` is ignored and FIFO N is flushed to empty on that cycle.
- Drop: a push into a full FIFO with no pop that cycle is discarded. In the same cycle, `ovf_flag[N]` is set and `ovf_cnt N` increments, saturating at 2^CNT_W−1.
- Push and pop in the same cycle on a full FIFO: the pop frees a slot and the push is accepted. No drop is counted.
- Output register load: the register loads when it is empty (`sd_vld`=0) or when it is being drained this cycle (`sd_vld & sd_rdy`).
- Grant selection: on a load, the arbiter grants the first non-empty enabled FIFO, searching from round-robin pointer `rr` upward modulo 3. The granted FIFO is popped, and `rr` becomes grant+1 modulo 3.
- No requester: if no FIFO is non-empty when the register would load, `sd_vld` goes low, or stays low after a drain.
- Hold: while `sd_vld & !sd_rdy`, `sd_data` and `sd_ch` stay stable and no FIFO is popped.
- Disable with output pending: clearing `ch_en[N]` while the output register holds a channel-N sample does not retract that sample; it is still delivered.
- `clr_ovf` and a drop in the same cycle: the clear wins for the flags. The counter for the dropping channel becomes 1, and its flag is set.
- FIFO pointers are log2(DEPTH) bits wide with an extra wrap bit. Full and empty are decided by comparing the wrap bits.
- Reset state:
  - `sd_vld`=0, `sd_data`=0, `sd_ch`=0
  - `ovf_flag`=0, all `ovf_cnt`=0
  - `rr`=0, all FIFOs empty
- Reset asserted mid-transfer: the pending output and all buffered samples are discarded. There is no partial-state recovery.

## Timing
- Latency: a sample pushed in cycle N into an empty system with `sd_rdy`=1 appears with `sd_vld`=1 in cycle N+2. Cycle N writes the FIFO; cycle N+1 arbitrates and loads the output register.
- Throughput: one sample per cycle while `sd_rdy`=1 and any FIFO is non-empty.
- Strobes arriving in the same cycle: all three are accepted in that cycle. Output order follows `rr`.
- Drop counters and flags update one cycle after the offending push. They are registered outputs.
- `ovf_flag` and `ovf_cnt` are registered and change only on `clk_sys` edges, or asynchronously on `rst`.

## Structure
- Package `ad_sched_pkg`:
  - `CH_NUM`=3
  - channel-tag type, 2 bits
  - tag constants `CH_AD1`=0, `CH_AD2`=1, `CH_AD3`=2
  - default `CH_W`/`DEPTH`/`CNT_W`
- Sub-module `ad_sched_fifo`, instantiated three times:
  - synchronous FIFO with `push`, `pop`, `flush`, `full`, `empty` and data out
  - includes the drop counter and sticky flag
- Top level holds only the round-robin arbiter and the output register.

## Test plan
- Reset, then `ad1_vld` for one cycle with 24'h123456 and `sd_rdy`=1 → `sd_vld`=1 exactly 2 cycles later with `sd_data`=24'h123456, `sd_ch`=0, then `sd_vld`=0.
- All three `vld` in one cycle with data A, B, C, `rr`=0, `sd_rdy`=1 → outputs A/0, B/1, C/2 on consecutive cycles. A second burst is then ordered starting from channel 0 again (`rr` wrapped to 0).
- `sd_rdy`=0, ad2 pushes 4 samples with DEPTH=2 → first sample held at the output, two more buffered. The 4th is dropped: `ovf_flag`=3'b010 and `ovf_cnt2`=1. After `sd_rdy`=1, the first three samples are delivered in order.
- 300 dropping pushes on ad3 with CNT_W=8 → `ovf_cnt3` saturates at 255. A `clr_ovf` pulse then gives 0 and `ovf_flag[2]`=0.
- FIFO1 holds 2 samples, then `ch_en[0]` drops to 0 and `ad1_vld` pulses → FIFO1 is flushed and the strobe is ignored. No ch0 output follows except a sample already in the output register.
- `rst` asserted while `sd_vld`=1 and FIFOs are non-empty → `sd_vld`=0 immediately (asynchronously). After release, there is no output until a new push.
